sar_adc_seq: RTL

//  Parametrised digital SAR conversion sequencer: drives sample/hold, channel mux and
//  DAC trial code of the analog front end; resolves one bit per SETTLE cycles from cmp.

---
 rtl/sar_adc_seq.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/sar_adc_seq.sv
// SAR conversion sequencer: sample/hold, channel scan and bitwise successive approximation,
// with a one-entry valid/ready result buffer that flags overwritten results.
module sar_adc_seq #(
    parameter int WIDTH  = 8,
    parameter int NCH    = 4,
    parameter int CHW    = 2,
    parameter int SAMPLE = 2,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             mode_cont,
    input  logic [NCH-1:0]   ch_mask,
    input  logic             cmp,
    output logic             busy,
    output logic             sample,
    output logic [CHW-1:0]   ch_sel,
    output logic [WIDTH-1:0] dac_code,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [CHW-1:0]   res_ch,
    output logic             overrun
);
    localparam int BW   = $clog2(WIDTH);
    localparam int CMAX = (SAMPLE > SETTLE) ? SAMPLE : SETTLE;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SAMPLE, S_CONVERT} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic             fin_q, fin_d;
    logic [NCH-1:0]   mask_q, mask_d;
    logic             cont_q, cont_d;
    logic             busy_q, busy_d;
    logic             sample_q, sample_d;
    logic [CHW-1:0]   ch_sel_q, ch_sel_d;
    logic [WIDTH-1:0] dac_code_q, dac_code_d;
    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic [CHW-1:0]   res_ch_q, res_ch_d;
    logic             overrun_q, overrun_d;

    logic [CHW-1:0]   st_ch, lo_ch, nx_ch;
    logic             nx_found;
    logic             load;
    logic [WIDTH-1:0] onehot;

    // Channel pickers: first set bit of the incoming mask, of the latched mask,
    // and the next set bit above the channel currently converting.
    always_comb begin
        st_ch    = '0;
        lo_ch    = '0;
        nx_ch    = '0;
        nx_found = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (ch_mask[i]) st_ch = CHW'(i);
            if (mask_q[i])  lo_ch = CHW'(i);
            if (mask_q[i] && (i > int'(ch_sel_q))) begin
                nx_ch    = CHW'(i);
                nx_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        fin_d       = fin_q;
        mask_d      = mask_q;
        cont_d      = cont_q;
        sample_d    = sample_q;
        ch_sel_d    = ch_sel_q;
        dac_code_d  = dac_code_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_ch_d    = res_ch_q;
        overrun_d   = 1'b0;
        load        = 1'b0;
        onehot      = WIDTH'(1) << bit_q;

        case (state_q)
            S_IDLE: begin
                if (start && !stop && (ch_mask != '0)) begin
                    state_d    = S_SAMPLE;
                    mask_d     = ch_mask;
                    cont_d     = mode_cont;
                    ch_sel_d   = st_ch;
                    sample_d   = 1'b1;
                    dac_code_d = '0;
                    cnt_d      = '0;
                end
            end
            S_SAMPLE: begin
                if (cnt_q == CW'(SAMPLE - 1)) begin
                    state_d    = S_CONVERT;
                    sample_d   = 1'b0;
                    dac_code_d = {1'b1, {(WIDTH-1){1'b0}}};
                    bit_d      = BW'(WIDTH - 1);
                    fin_d      = 1'b0;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CONVERT: begin
                if (fin_q) begin
                    // Final code has been on the DAC for one cycle; hand it off.
                    load       = 1'b1;
                    dac_code_d = '0;
                    cnt_d      = '0;
                    if (nx_found || cont_q) begin
                        state_d  = S_SAMPLE;
                        sample_d = 1'b1;
                        ch_sel_d = nx_found ? nx_ch : lo_ch;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (cnt_q == CW'(SETTLE - 1)) begin
                    cnt_d      = '0;
                    dac_code_d = (dac_code_q & ~onehot) | (cmp ? onehot : '0) | (onehot >> 1);
                    if (bit_q == '0) fin_d = 1'b1;
                    else             bit_d = bit_q - 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (stop && (state_q != S_IDLE)) begin
            state_d    = S_IDLE;
            sample_d   = 1'b0;
            dac_code_d = '0;
            load       = 1'b0;
        end

        if (load) begin
            res_valid_d = 1'b1;
            res_data_d  = dac_code_q;
            res_ch_d    = ch_sel_q;
            overrun_d   = res_valid_q & ~res_ready;
        end else if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            fin_q       <= 1'b0;
            mask_q      <= '0;
            cont_q      <= 1'b0;
            busy_q      <= 1'b0;
            sample_q    <= 1'b0;
            ch_sel_q    <= '0;
            dac_code_q  <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_ch_q    <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            fin_q       <= fin_d;
            mask_q      <= mask_d;
            cont_q      <= cont_d;
            busy_q      <= busy_d;
            sample_q    <= sample_d;
            ch_sel_q    <= ch_sel_d;
            dac_code_q  <= dac_code_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_ch_q    <= res_ch_d;
            overrun_q   <= overrun_d;
        end
    end

    assign busy      = busy_q;
    assign sample    = sample_q;
    assign ch_sel    = ch_sel_q;
    assign dac_code  = dac_code_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_ch    = res_ch_q;
    assign overrun   = overrun_q;

endmodule
